// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_DW = 32;

  // Who owns the access currently in flight toward the memory.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DLD   = 2'd2,
    OWN_DST   = 2'd3
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = mem_port_arbiter_pkg::DEFAULT_AW,
  parameter int DW = mem_port_arbiter_pkg::DEFAULT_DW
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic            d_req;
  logic            d_we;
  logic [DW/8-1:0] d_be;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;

  logic            m_en;
  logic            m_we;
  logic [DW/8-1:0] m_be;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_be, m_addr, m_wdata
  );

  // Core pipeline plus memory side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_be, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_arb_fixed_fair.sv
// Data-priority grant logic with a bounded data streak so a waiting fetch is
// never starved for more than MAX_DATA_BURST contended cycles.
module arb_fixed_fair #(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  localparam int SW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_BURST);

  logic [SW-1:0] streak_q, streak_d;

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    if_gnt   = 1'b0;
    d_gnt    = 1'b0;
    streak_d = streak_q;

    if (!rst) begin
      d_gnt  = d_req && !(if_req && (streak_q == STREAK_MAX));
      if_gnt = if_req && !d_gnt;
    end

    // The streak only measures how long a fetch has been kept waiting.
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the values from before the edge, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, and
// steers the 1-cycle-latency read data back to whichever requester owns it.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW             = DEFAULT_AW,
  parameter int DW             = DEFAULT_DW,
  parameter int MAX_DATA_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  logic   if_gnt, d_gnt;
  owner_e owner_q, owner_d;

  arb_fixed_fair #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .if_req(bus.if_req),
    .d_req (bus.d_req),
    .if_gnt(if_gnt),
    .d_gnt (d_gnt)
  );

  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt  = d_gnt;

  // The memory port follows the winner in the same cycle; idle fields read 0.
  always_comb begin
    bus.m_en    = if_gnt | d_gnt;
    bus.m_we    = 1'b0;
    bus.m_be    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    owner_d     = OWN_NONE;

    if (d_gnt) begin
      bus.m_we    = bus.d_we;
      bus.m_be    = bus.d_we ? bus.d_be : '1;
      bus.m_addr  = bus.d_addr;
      bus.m_wdata = bus.d_wdata;
      owner_d     = bus.d_we ? OWN_DST : OWN_DLD;
    end else if (if_gnt) begin
      bus.m_be   = '1;
      bus.m_addr = bus.if_addr;
      owner_d    = OWN_FETCH;
    end
  end

  // Reset clears the owner, which drops any access already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign bus.if_rvalid = (owner_q == OWN_FETCH);
  assign bus.d_rvalid  = (owner_q == OWN_DLD) || (owner_q == OWN_DST);
  assign bus.if_rdata  = (owner_q == OWN_FETCH) ? bus.m_rdata : '0;
  assign bus.d_rdata   = (owner_q == OWN_DLD)   ? bus.m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a word-level
// memory image and a rule-based model of fetch starvation.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MAX_DATA_BURST(MAXB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: how many data grants in a row a fetch has been waiting for,
  // plus a shadow of the memory contents.
  int          run;
  logic [31:0] sh     [256];
  logic        sh_wr  [256];

  // Memory instance: 1-cycle read latency, byte-enabled writes.
  logic [31:0] mem    [256];
  logic        mem_wr [256];

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return 32'hA5000000 | {16'd0, i, ~i};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_word(input logic [7:0] i);
    return (mem_wr[i] === 1'b1) ? mem[i] : init_word(i);
  endfunction

  function automatic logic [31:0] exp_word(input logic [7:0] i);
    return (sh_wr[i] === 1'b1) ? sh[i] : init_word(i);
  endfunction

  always @(posedge clk) begin
    if (bus.m_en === 1'b1) begin
      if (bus.m_we) begin
        mem[bus.m_addr[9:2]]    <= merge(mem_word(bus.m_addr[9:2]), bus.m_wdata, bus.m_be);
        mem_wr[bus.m_addr[9:2]] <= 1'b1;
      end else begin
        bus.m_rdata <= mem_word(bus.m_addr[9:2]);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle, entered #1 after a rising edge with requests driven.
  task automatic cycle(input string tag, output logic gd, output logic gf);
    int          kind;
    logic [7:0]  idx;
    kind = 0;
    idx  = '0;
    #4;
    gd = bus.d_req && !(bus.if_req && run == MAXB);
    gf = bus.if_req && !gd;
    check({tag, ".d_gnt"}, 32'(bus.d_gnt), 32'(gd));
    check({tag, ".if_gnt"}, 32'(bus.if_gnt), 32'(gf));
    check({tag, ".m_en"}, 32'(bus.m_en), 32'(gd | gf));
    if (gd) begin
      check({tag, ".m_we"}, 32'(bus.m_we), 32'(bus.d_we));
      check({tag, ".m_be"}, 32'(bus.m_be), bus.d_we ? 32'(bus.d_be) : 32'hF);
      check({tag, ".m_addr"}, bus.m_addr, bus.d_addr);
      idx = bus.d_addr[9:2];
      if (bus.d_we) begin
        check({tag, ".m_wdata"}, bus.m_wdata, bus.d_wdata);
        sh[idx]    = merge(exp_word(idx), bus.d_wdata, bus.d_be);
        sh_wr[idx] = 1'b1;
        kind = 3;
      end else begin
        kind = 2;
      end
    end else if (gf) begin
      check({tag, ".m_we"}, 32'(bus.m_we), 32'd0);
      check({tag, ".m_be"}, 32'(bus.m_be), 32'hF);
      check({tag, ".m_addr"}, bus.m_addr, bus.if_addr);
      idx  = bus.if_addr[9:2];
      kind = 1;
    end
    if (!bus.if_req || gf) run = 0;
    else if (gd && run < MAXB) run++;

    @(posedge clk);
    #1;
    check({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 32'(kind == 1));
    check({tag, ".d_rvalid"}, 32'(bus.d_rvalid), 32'(kind >= 2));
    if (kind == 1) check({tag, ".if_rdata"}, bus.if_rdata, exp_word(idx));
    if (kind == 2) check({tag, ".d_rdata"}, bus.d_rdata, exp_word(idx));
  endtask

  task automatic set_data(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.d_req   = req;
    bus.d_we    = we;
    bus.d_be    = be;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
  endtask

  initial begin
    logic        gd, gf;
    logic [9:0]  seq10;
    logic [8:0]  seq9;
    logic        if_act, d_act;
    logic [31:0] r;

    for (int i = 0; i < 256; i++) sh_wr[i] = 1'b0;
    run = 0;
    rst = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset state, including grants held off while requests are present.
    #12;
    check("rst.if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("rst.d_rvalid", 32'(bus.d_rvalid), 32'd0);
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    #1;
    check("rst.if_gnt", 32'(bus.if_gnt), 32'd0);
    check("rst.d_gnt", 32'(bus.d_gnt), 32'd0);
    check("rst.m_en", 32'(bus.m_en), 32'd0);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fetch only: place the instruction, then fetch it.
    set_data(1'b1, 1'b1, 4'hF, 32'h100, 32'h00500093);
    cycle("st_insn", gd, gf);
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    cycle("fetch", gd, gf);
    check("fetch.word", bus.if_rdata, 32'h00500093);
    bus.if_req = 1'b0;

    // Partial store over a known word, then load it back.
    set_data(1'b1, 1'b1, 4'hF, 32'h200, 32'h11223344);
    cycle("st_full", gd, gf);
    set_data(1'b1, 1'b1, 4'b0011, 32'h200, 32'hAABBCCDD);
    cycle("st_half", gd, gf);
    set_data(1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
    cycle("ld_half", gd, gf);
    check("ld_half.word", bus.d_rdata, 32'h1122CCDD);

    // Contention: both requests held for 10 cycles.
    seq10 = '0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    for (int c = 0; c < 10; c++) begin
      cycle("contend", gd, gf);
      seq10 = {seq10[8:0], gd};
    end
    check("contend.seq", 32'(seq10), 32'(10'b1111011110));

    // Streak clears when the fetch request drops for one cycle.
    seq9 = '0;
    for (int c = 0; c < 9; c++) begin
      bus.if_req = (c != 3);
      cycle("starve", gd, gf);
      seq9 = {seq9[7:0], gd};
    end
    check("starve.seq", 32'(seq9), 32'(9'b111111110));

    // Reset lands between a load grant and its response edge.
    bus.if_req = 1'b0;
    cycle("idle", gd, gf);
    set_data(1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
    #4;
    check("flight.d_gnt", 32'(bus.d_gnt), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("flight.d_gnt_rst", 32'(bus.d_gnt), 32'd0);
    check("flight.m_en", 32'(bus.m_en), 32'd0);
    check("flight.m_addr", bus.m_addr, 32'd0);
    @(posedge clk);
    #1;
    check("flight.d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("flight.if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("flight.d_rdata", bus.d_rdata, 32'd0);
    set_data(1'b0, 1'b0, 4'h0, 32'h200, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run = 0;
    @(posedge clk);
    #1;
    seq9 = '0;
    bus.if_req = 1'b1;
    set_data(1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
    for (int c = 0; c < 5; c++) begin
      cycle("post_rst", gd, gf);
      seq9 = {seq9[7:0], gd};
    end
    check("post_rst.seq", 32'(seq9), 32'(9'b000011110));

    // Randomized traffic; requests hold until granted, occasionally withdrawn.
    if_act = 1'b0;
    d_act  = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!if_act && ($urandom_range(0, 1) == 1)) begin
        r = $urandom;
        bus.if_addr = {22'd0, r[7:0], 2'b00};
        if_act = 1'b1;
      end else if (if_act && ($urandom_range(0, 15) == 0)) begin
        if_act = 1'b0;
      end
      if (!d_act && ($urandom_range(0, 3) != 0)) begin
        r = $urandom;
        set_data(1'b1, r[31], r[30:27], {22'd0, 3'd0, r[4:0], 2'b00}, $urandom);
        d_act = 1'b1;
      end else if (d_act && ($urandom_range(0, 15) == 0)) begin
        d_act = 1'b0;
      end
      bus.if_req = if_act;
      bus.d_req  = d_act;
      cycle("rand", gd, gf);
      if (gd) d_act = 1'b0;
      if (gf) if_act = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
